// File: rtl/uart_frame_packer.sv
// rtl/uart_frame_packer.sv - packs FIFO-buffered 16-bit samples into A5 5A LEN DATA.. [CHK] byte frames.
// Optional checksum byte enabled by defining FRAME_CHECKSUM_EN.
module uart_frame_packer #(
    parameter int FRAME_LEN  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [15:0] s_smp_data,
    input  logic        s_smp_valid,
    output logic        s_smp_ready,
    output logic [7:0]  m_tx_data,
    output logic        m_tx_valid,
    input  logic        m_tx_ready,
    output logic        busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    typedef logic [AW:0]   cnt_t;
    typedef logic [AW-1:0] ptr_t;
    localparam cnt_t       DEPTH_C  = cnt_t'(FIFO_DEPTH);
    localparam cnt_t       FLEN_C   = cnt_t'(FRAME_LEN);
    localparam logic [7:0] LEN_BYTE = 8'(FRAME_LEN);
    localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

    typedef enum logic [2:0] {
        IDLE, HDR0, HDR1, LEN, DATA_H, DATA_L, CHK
    } state_t;

    logic [15:0] mem_q [FIFO_DEPTH];
    ptr_t        wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
    cnt_t        count_q;
    logic        push, pop, accept;
    logic [15:0] head, head_next;

    state_t      state_q, state_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  smp_cnt_q, smp_cnt_d;

    assign s_smp_ready = (count_q != DEPTH_C);
    assign push        = s_smp_valid && s_smp_ready;
    assign accept      = tx_valid_q && m_tx_ready;
    assign rd_ptr_nxt  = rd_ptr_q + ptr_t'(1);
    assign head        = mem_q[rd_ptr_q];
    // The whole frame is resident before HDR0, so the next entry is always valid.
    assign head_next   = mem_q[rd_ptr_nxt];

    assign m_tx_data   = tx_data_q;
    assign m_tx_valid  = tx_valid_q;
    assign busy        = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_smp_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + ptr_t'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_nxt;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + cnt_t'(1);
                2'b01:   count_q <= count_q - cnt_t'(1);
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef FRAME_CHECKSUM_EN
    logic [7:0] chk_q, chk_sum;
    logic       chk_acc;

    assign chk_sum = chk_q + tx_data_q;
    assign chk_acc = accept && (state_q == LEN || state_q == DATA_H || state_q == DATA_L);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            chk_q <= '0;
        end else if (state_q == IDLE) begin
            chk_q <= '0;
        end else if (chk_acc) begin
            chk_q <= chk_sum;
        end
    end
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            smp_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            smp_cnt_q  <= smp_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        smp_cnt_d  = smp_cnt_q;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                tx_valid_d = 1'b0;
                if (count_q >= FLEN_C) begin
                    state_d    = HDR0;
                    tx_valid_d = 1'b1;
                    tx_data_d  = 8'hA5;
                    smp_cnt_d  = '0;
                end
            end
            HDR0: begin
                if (accept) begin
                    state_d   = HDR1;
                    tx_data_d = 8'h5A;
                end
            end
            HDR1: begin
                if (accept) begin
                    state_d   = LEN;
                    tx_data_d = LEN_BYTE;
                end
            end
            LEN: begin
                if (accept) begin
                    state_d   = DATA_H;
                    tx_data_d = head[15:8];
                end
            end
            DATA_H: begin
                if (accept) begin
                    state_d   = DATA_L;
                    tx_data_d = head[7:0];
                end
            end
            DATA_L: begin
                if (accept) begin
                    pop = 1'b1;
                    if (smp_cnt_q < LAST_IDX) begin
                        smp_cnt_d = smp_cnt_q + 8'd1;
                        state_d   = DATA_H;
                        tx_data_d = head_next[15:8];
                    end else begin
`ifdef FRAME_CHECKSUM_EN
                        state_d   = CHK;
                        tx_data_d = chk_sum;
`else
                        state_d    = IDLE;
                        tx_valid_d = 1'b0;
                        tx_data_d  = 8'h00;
`endif
                    end
                end
            end
            CHK: begin
                if (accept) begin
                    state_d    = IDLE;
                    tx_valid_d = 1'b0;
                    tx_data_d  = 8'h00;
                end
            end
            default: begin
                state_d    = IDLE;
                tx_valid_d = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/uart_frame_packer.md
UART_FRAME_PACKER -- requirements
Module: uart_frame_packer

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 8, samples per frame (legal range 1..255, and FRAME_LEN <= FIFO_DEPTH).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, sample FIFO entries (power of two, >= 2).
REQ-003 SHALL have port clk  input  1  clock; all logic on posedge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port s_smp_data  input  16  sample word from the FFT magnitude stage.
REQ-006 SHALL have port s_smp_valid  input  1  sample valid.
REQ-007 SHALL have port s_smp_ready  output  1  sample accepted when valid&&ready.
REQ-008 SHALL have port m_tx_data  output  8  byte to the UART transmitter.
REQ-009 SHALL have port m_tx_valid  output  1  byte valid.
REQ-010 SHALL have port m_tx_ready  input  1  byte consumed when valid&&ready.
REQ-011 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-012 SHALL buffer samples in a FIFO_DEPTH x 16 FIFO; s_smp_ready = !full, combinational from the registered count.
REQ-013 SHALL run FSM states IDLE, HDR0, HDR1, LEN, DATA_H, DATA_L, CHK.
REQ-014 IDLE->HDR0 SHALL occur at the first edge where FIFO count >= FRAME_LEN; m_tx_valid=1 and m_tx_data=0xA5 SHALL be registered at that edge.
REQ-015 Each byte state SHALL advance only on m_tx_valid&&m_tx_ready, in this order: HDR0 (0xA5), HDR1 (0x5A), LEN (FRAME_LEN[7:0]), then DATA_H (sample[15:8]) and DATA_L (sample[7:0]) repeated FRAME_LEN times, then CHK, then IDLE.
REQ-016 Every next byte SHALL be presented on the edge of the accepting handshake, giving zero bubble cycles while m_tx_ready=1.
REQ-017 m_tx_data SHALL stay stable and m_tx_valid SHALL stay high while m_tx_valid&&!m_tx_ready.
REQ-018 The FIFO head SHALL be popped on DATA_L acceptance; a per-frame sample counter SHALL select DATA_H (counter < FRAME_LEN-1) or CHK as the next state.
REQ-019 A simultaneous push and pop SHALL leave the count unchanged with no data loss; a push while full SHALL be impossible because ready is low.
REQ-020 The checksum SHALL be the 8-bit modulo-256 sum of the LEN byte and all data bytes; header bytes are excluded.
REQ-021 CHK acceptance SHALL return the FSM to IDLE with m_tx_valid=0 for at least one cycle; back-to-back frames SHALL restart per REQ-014.

Reset
REQ-022 On rstn low: FSM=IDLE, FIFO empty (pointers and count 0), m_tx_valid=0, m_tx_data=0x00, busy=0, checksum and sample counter 0; s_smp_ready=1.
REQ-023 Reset mid-frame SHALL abort the frame immediately and discard all buffered samples; no partial byte SHALL be emitted after release.

Configuration
REQ-024 With macro FRAME_CHECKSUM_EN defined, the CHK state and checksum logic SHALL be present per REQ-020.
REQ-025 Without FRAME_CHECKSUM_EN, the last DATA_L acceptance SHALL go directly to IDLE; frames SHALL be 3+2*FRAME_LEN bytes, and no checksum register SHALL be synthesized.

Verification
REQ-026 FRAME_LEN=2, push 0x1234 and 0xABCD, m_tx_ready=1 -> bytes A5 5A 02 12 34 AB CD C0 on consecutive cycles, then valid=0.
REQ-027 Same stimulus with m_tx_ready held low 10 cycles while 0x12 is presented -> m_tx_data stays 0x12 and valid stays 1, and the stream is otherwise identical.
REQ-028 FIFO_DEPTH=4, FRAME_LEN=4, m_tx_ready=0, push 5 samples -> s_smp_ready=0 after the 4th push, the 5th sample is held by the source, and the frame later emits samples 1-4 in order.
REQ-029 Push one sample per cycle while draining continuously at FRAME_LEN=2 -> no sample lost or duplicated across 3 frames, and checksums are correct.
REQ-030 Assert rstn during DATA_L of frame 1 -> outputs take reset values; after release, a new 2-sample push yields a clean frame starting with A5.
REQ-031 FRAME_CHECKSUM_EN undefined, REQ-026 stimulus -> A5 5A 02 12 34 AB CD, then valid=0.
